// File: rtl/lcd_seq_ctrl_if.sv
// Request/handshake bundle between the LCD control FSM, the write engine
// and the write sequencer. The master side issues requests and returns
// write completions; the slave side is the sequencer itself.
interface lcd_seq_ctrl_if #(
  parameter int IDX_W = 2,
  parameter int GAP_W = 8
);
  logic             lcd_enable;
  logic             mode;
  logic [IDX_W-1:0] lcd_cnt;
  logic [GAP_W-1:0] gap;
  logic             abort;
  logic             wr_finish;
  logic             wr_enable;
  logic [IDX_W-1:0] init_sel;
  logic [IDX_W-1:0] mux_sel;
  logic             busy;
  logic             lcd_finish;
  logic             timeout_err;

  modport master (
    output lcd_enable, mode, lcd_cnt, gap, abort, wr_finish,
    input  wr_enable, init_sel, mux_sel, busy, lcd_finish, timeout_err
  );

  modport slave (
    input  lcd_enable, mode, lcd_cnt, gap, abort, wr_finish,
    output wr_enable, init_sel, mux_sel, busy, lcd_finish, timeout_err
  );
endinterface

// File: rtl/lcd_seq_ctrl.sv
// LCD write sequencer: walks an init-ROM or refresh-mux index from a start
// count down to zero, one write strobe per index, with an optional gap after
// each acknowledge, an ack timeout, abort, and a one-cycle finish pulse.
module lcd_seq_ctrl #(
  parameter int IDX_W  = 2,
  parameter int GAP_W  = 8,
  parameter int TO_W   = 16,
  parameter int TO_CYC = 16'hFFFF
) (
  input logic             clk,
  input logic             rst_n,
  lcd_seq_ctrl_if.slave   bus_if
);

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    WAIT_ACK,
    GAP,
    DONE
  } state_t;

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TO_CYC - 1);

  state_t             state_q, state_d;
  logic               mode_q, mode_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
  logic [TO_W-1:0]    to_cnt_q, to_cnt_d;
  logic [IDX_W-1:0]   init_sel_q, init_sel_d;
  logic [IDX_W-1:0]   mux_sel_q, mux_sel_d;
  logic               wr_en_q, wr_en_d;
  logic               busy_q, busy_d;
  logic               fin_q, fin_d;
  logic               to_err_q, to_err_d;
  logic [IDX_W-1:0]   idx;

  assign idx = mode_q ? init_sel_q : mux_sel_q;

  // Next-state logic; outputs are derived from the next state so that every
  // output, the write strobe included, comes straight from a flop.
  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    gap_d      = gap_q;
    gap_cnt_d  = gap_cnt_q;
    to_cnt_d   = to_cnt_q;
    init_sel_d = init_sel_q;
    mux_sel_d  = mux_sel_q;
    to_err_d   = to_err_q;

    case (state_q)
      IDLE: begin
        if (bus_if.lcd_enable) begin
          mode_d   = bus_if.mode;
          gap_d    = bus_if.gap;
          to_err_d = 1'b0;
          if (bus_if.mode) init_sel_d = bus_if.lcd_cnt;
          else             mux_sel_d  = bus_if.lcd_cnt;
          state_d  = WRITE;
        end
      end
      WRITE: begin
        to_cnt_d = '0;
        state_d  = bus_if.abort ? DONE : WAIT_ACK;
      end
      WAIT_ACK: begin
        if (bus_if.abort) begin
          state_d = DONE;
        end else if (bus_if.wr_finish) begin
          if (idx != '0) begin
            if (mode_q) init_sel_d = init_sel_q - IDX_W'(1);
            else        mux_sel_d  = mux_sel_q - IDX_W'(1);
            if (gap_q != '0) begin
              gap_cnt_d = gap_q - GAP_W'(1);
              state_d   = GAP;
            end else begin
              state_d   = WRITE;
            end
          end else begin
            state_d = DONE;
          end
        end else if (to_cnt_q == TO_LAST) begin
          to_err_d = 1'b1;
          state_d  = DONE;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
      end
      GAP: begin
        if (bus_if.abort)            state_d = DONE;
        else if (gap_cnt_q == '0)    state_d = WRITE;
        else                         gap_cnt_d = gap_cnt_q - GAP_W'(1);
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    wr_en_d = (state_d == WRITE);
    busy_d  = (state_d != IDLE);
    fin_d   = (state_d == DONE);
  end

  // State and output registers; reset returns everything to zero at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      mode_q     <= 1'b0;
      gap_q      <= '0;
      gap_cnt_q  <= '0;
      to_cnt_q   <= '0;
      init_sel_q <= '0;
      mux_sel_q  <= '0;
      wr_en_q    <= 1'b0;
      busy_q     <= 1'b0;
      fin_q      <= 1'b0;
      to_err_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      gap_q      <= gap_d;
      gap_cnt_q  <= gap_cnt_d;
      to_cnt_q   <= to_cnt_d;
      init_sel_q <= init_sel_d;
      mux_sel_q  <= mux_sel_d;
      wr_en_q    <= wr_en_d;
      busy_q     <= busy_d;
      fin_q      <= fin_d;
      to_err_q   <= to_err_d;
    end
  end

  assign bus_if.wr_enable   = wr_en_q;
  assign bus_if.init_sel    = init_sel_q;
  assign bus_if.mux_sel     = mux_sel_q;
  assign bus_if.busy        = busy_q;
  assign bus_if.lcd_finish  = fin_q;
  assign bus_if.timeout_err = to_err_q;

endmodule

// File: tb/tb_lcd_seq_ctrl.sv
// Directed bench for lcd_seq_ctrl: refresh and init walks, gaps, timeout,
// abort, zero-length and back-to-back sequences, and mid-sequence reset.
module tb_lcd_seq_ctrl;

  logic clk;
  logic rst_n;
  int   testsRun;
  int   testsFailed;
  int   cyc;
  int   ackDelay;
  bit   ackEn;
  int   ackTimer;
  int   strobeCnt;
  int   finCnt;
  int   strobeCyc[$];
  logic [1:0] initLog[$];
  logic [1:0] muxLog[$];

  lcd_seq_ctrl_if #(.IDX_W(2), .GAP_W(8)) bus ();

  lcd_seq_ctrl #(.IDX_W(2), .GAP_W(8), .TO_W(16), .TO_CYC(4)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus_if (bus)
  );

  // Free-running clock and cycle counter.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  // Observe strobes and finish pulses mid-cycle, logging selects per strobe.
  initial begin
    strobeCnt = 0;
    finCnt = 0;
    forever begin
      @(negedge clk);
      if (bus.wr_enable === 1'b1) begin
        strobeCnt++;
        strobeCyc.push_back(cyc);
        initLog.push_back(bus.init_sel);
        muxLog.push_back(bus.mux_sel);
      end
      if (bus.lcd_finish === 1'b1) finCnt++;
    end
  end

  // Write-engine model: one-cycle wr_finish ackDelay cycles after a strobe.
  initial begin
    ackTimer = 0;
    bus.wr_finish = 1'b0;
    forever begin
      @(negedge clk);
      if (ackEn && bus.wr_enable === 1'b1) begin
        ackTimer = ackDelay;
        bus.wr_finish = 1'b0;
      end else if (ackTimer > 0) begin
        ackTimer--;
        bus.wr_finish = ackEn && (ackTimer == 0);
      end else begin
        bus.wr_finish = 1'b0;
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testsRun++;
    assert (obs === exp) else begin
      testsFailed++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Present a start request, let one edge sample it, return 1 time unit later.
  task automatic applyStimulus(input logic m, input logic [1:0] cnt, input logic [7:0] g);
    bus.lcd_enable = 1'b1;
    bus.mode       = m;
    bus.lcd_cnt    = cnt;
    bus.gap        = g;
    @(posedge clk);
    #1;
    bus.lcd_enable = 1'b0;
  endtask

  // Count edges after the start edge until lcd_finish shows, bounded.
  task automatic waitFinish(output int edges, output int busyDrops);
    bit got;
    got = 0;
    edges = 0;
    busyDrops = 0;
    for (int i = 0; i < 300 && !got; i++) begin
      @(posedge clk);
      #1;
      edges++;
      if (bus.lcd_finish === 1'b1) got = 1;
      else if (bus.busy !== 1'b1) busyDrops++;
    end
    if (!got) begin
      testsRun++;
      testsFailed++;
      $error("[TB] FAIL finish_wait: observed no lcd_finish within 300 cycles, expected a pulse");
    end
  endtask

  initial begin
    int edges;
    int drops;
    int sBase;
    int fBase;
    testsRun = 0;
    testsFailed = 0;
    ackEn = 1'b0;
    ackDelay = 2;
    rst_n = 1'b0;
    bus.lcd_enable = 1'b0;
    bus.mode = 1'b0;
    bus.lcd_cnt = '0;
    bus.gap = '0;
    bus.abort = 1'b0;

    // Reset state.
    #3;
    checkOutput("rst_wr_enable", bus.wr_enable, 0);
    checkOutput("rst_init_sel", bus.init_sel, 0);
    checkOutput("rst_mux_sel", bus.mux_sel, 0);
    checkOutput("rst_busy", bus.busy, 0);
    checkOutput("rst_lcd_finish", bus.lcd_finish, 0);
    checkOutput("rst_timeout_err", bus.timeout_err, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Refresh walk, K=3, G=0, A=2: 4 strobes, 13 cycles inclusive.
    $display("[TB] refresh K=3 G=0");
    ackEn = 1'b1;
    sBase = strobeCnt;
    fBase = finCnt;
    applyStimulus(1'b0, 2'd3, 8'd0);
    checkOutput("t1_busy_start", bus.busy, 1);
    waitFinish(edges, drops);
    checkOutput("t1_cycles", edges + 1, 13);
    checkOutput("t1_busy_drops", drops, 0);
    checkOutput("t1_strobes", strobeCnt - sBase, 4);
    for (int i = 0; i < 4; i++) checkOutput($sformatf("t1_mux_sel_%0d", i), muxLog[sBase + i], 3 - i);
    checkOutput("t1_init_sel", bus.init_sel, 0);
    checkOutput("t1_spacing", strobeCyc[sBase + 1] - strobeCyc[sBase], 3);
    @(posedge clk); #1;
    checkOutput("t1_idle_busy", bus.busy, 0);
    checkOutput("t1_idle_finish", bus.lcd_finish, 0);
    checkOutput("t1_fin_pulses", finCnt - fBase, 1);

    // Init walk, K=2, G=5: strobes 8 cycles apart, 20 cycles inclusive.
    $display("[TB] init K=2 G=5");
    sBase = strobeCnt;
    applyStimulus(1'b1, 2'd2, 8'd5);
    waitFinish(edges, drops);
    checkOutput("t2_cycles", edges + 1, 20);
    checkOutput("t2_strobes", strobeCnt - sBase, 3);
    for (int i = 0; i < 3; i++) checkOutput($sformatf("t2_init_sel_%0d", i), initLog[sBase + i], 2 - i);
    checkOutput("t2_spacing_a", strobeCyc[sBase + 1] - strobeCyc[sBase], 8);
    checkOutput("t2_spacing_b", strobeCyc[sBase + 2] - strobeCyc[sBase + 1], 8);
    checkOutput("t2_mux_sel", bus.mux_sel, 0);
    @(posedge clk); #1;

    // Ack timeout after 4 WAIT_ACK cycles, K=1 init.
    $display("[TB] timeout K=1");
    ackEn = 1'b0;
    sBase = strobeCnt;
    applyStimulus(1'b1, 2'd1, 8'd0);
    waitFinish(edges, drops);
    checkOutput("t3_cycles", edges + 1, 6);
    checkOutput("t3_timeout_err", bus.timeout_err, 1);
    checkOutput("t3_strobes", strobeCnt - sBase, 1);
    checkOutput("t3_init_sel", bus.init_sel, 1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    checkOutput("t3_err_sticky", bus.timeout_err, 1);

    // Abort in the gap before the second write of a K=3 refresh.
    $display("[TB] abort in gap");
    ackEn = 1'b1;
    sBase = strobeCnt;
    fBase = finCnt;
    applyStimulus(1'b0, 2'd3, 8'd5);
    checkOutput("t4_err_cleared", bus.timeout_err, 0);
    repeat (4) begin @(posedge clk); #1; end
    bus.abort = 1'b1;
    @(posedge clk); #1;
    bus.abort = 1'b0;
    checkOutput("t4_finish", bus.lcd_finish, 1);
    checkOutput("t4_mux_sel", bus.mux_sel, 2);
    repeat (6) begin @(posedge clk); #1; end
    checkOutput("t4_strobes", strobeCnt - sBase, 1);
    checkOutput("t4_fin_pulses", finCnt - fBase, 1);

    // Zero-length sequence with lcd_enable held high: one idle cycle between runs.
    $display("[TB] K=0 back to back");
    sBase = strobeCnt;
    bus.lcd_enable = 1'b1;
    bus.mode = 1'b0;
    bus.lcd_cnt = 2'd0;
    bus.gap = 8'd0;
    @(posedge clk); #1;
    waitFinish(edges, drops);
    checkOutput("t5_cycles", edges + 1, 4);
    checkOutput("t5_strobes", strobeCnt - sBase, 1);
    @(posedge clk); #1;
    checkOutput("t5_idle_gap", bus.busy, 0);
    @(posedge clk); #1;
    checkOutput("t5_restart_busy", bus.busy, 1);
    checkOutput("t5_restart_wr", bus.wr_enable, 1);
    bus.lcd_enable = 1'b0;
    waitFinish(edges, drops);
    checkOutput("t5_strobes_total", strobeCnt - sBase, 2);
    @(posedge clk); #1;

    // Reset while waiting for an ack, then a clean restart.
    $display("[TB] reset mid-sequence");
    fBase = finCnt;
    applyStimulus(1'b1, 2'd2, 8'd0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    checkOutput("t6_busy", bus.busy, 0);
    checkOutput("t6_wr_enable", bus.wr_enable, 0);
    checkOutput("t6_init_sel", bus.init_sel, 0);
    checkOutput("t6_finish", bus.lcd_finish, 0);
    repeat (3) begin @(posedge clk); #1; end
    rst_n = 1'b1;
    checkOutput("t6_no_fin", finCnt - fBase, 0);
    @(posedge clk); #1;
    sBase = strobeCnt;
    applyStimulus(1'b1, 2'd1, 8'd0);
    waitFinish(edges, drops);
    checkOutput("t6_cycles", edges + 1, 7);
    checkOutput("t6_strobes", strobeCnt - sBase, 2);
    checkOutput("t6_init_end", bus.init_sel, 0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
